// File: rtl/axi_lite_pixel_sink_pkg.sv
// Shared definitions for the AXI4-Lite pixel sink: response codes, B-channel
// state encoding and default widths.
package axi_lite_pixel_sink_pkg;

  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_MEM_DEPTH   = 256;
  localparam int DEF_FRAME_WORDS = 256;

  // Same encodings the accelerator uses for its response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    B_IDLE = 1'b0,
    B_WAIT = 1'b1
  } b_state_e;

endpackage

// File: rtl/axi_lite_pixel_sink_if.sv
// AXI4-Lite write-only channel bundle (AW, W, B) between the accelerator
// master and the pixel sink.
interface axi_lite_pixel_sink_if
  import axi_lite_pixel_sink_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );

endinterface

// File: rtl/axi_lite_pixel_sink_pixel_ram.sv
// Pixel RAM: one byte-enabled synchronous write port and one read-first
// registered read port; out-of-range reads return zero.
module axi_lite_pixel_sink_pixel_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    ACLK,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_ok;

  assign wr_idx = wr_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];
  assign rd_ok  = 32'(rd_addr) < 32'(MEM_DEPTH);

  // Each byte lane is its own narrow memory column, so a strobe simply gates
  // that column's write enable.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [7:0] mem [MEM_DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge ACLK) begin
        if (wr_en && wr_strb[gi]) begin
          mem[wr_idx] <= wr_data[gi*8 +: 8];
        end
      end

      always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
          rd_byte_reg <= '0;
        end else if (rd_ok) begin
          rd_byte_reg <= mem[rd_idx];
        end else begin
          rd_byte_reg <= '0;
        end
      end

      assign rd_data[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

endmodule

// File: rtl/axi_lite_pixel_sink.sv
// AXI4-Lite write-only pixel sink: independent AW/W holding registers, byte-
// strobed commit into pixel RAM, B response FSM. Define FRAME_IRQ_EN for the
// frame counter and the frame_done_irq output.
module axi_lite_pixel_sink
  import axi_lite_pixel_sink_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                  ACLK,
  input  logic                  reset,
  axi_lite_pixel_sink_if.slave  s_axi,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
`ifdef FRAME_IRQ_EN
  ,
  output logic                  frame_done_irq
`endif
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  alive_reg;
  logic                  aw_full_reg;
  logic [ADDR_WIDTH-1:0] aw_addr_reg;
  logic                  w_full_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;
  logic [STRB_WIDTH-1:0] w_strb_reg;
  logic [1:0]            bresp_reg;
  b_state_e              b_state_reg;
  b_state_e              b_state_next;

  logic aw_hs;
  logic w_hs;
  logic bvalid;
  logic commit;
  logic addr_ok;
  logic unused_prot;

  assign unused_prot = ^s_axi.AWPROT;

  // alive_reg keeps both READYs low until the first edge after reset.
  assign s_axi.AWREADY = alive_reg & ~aw_full_reg;
  assign s_axi.WREADY  = alive_reg & ~w_full_reg;
  assign bvalid        = (b_state_reg == B_WAIT);
  assign s_axi.BVALID  = bvalid;
  assign s_axi.BRESP   = bresp_reg;

  assign aw_hs   = s_axi.AWVALID & s_axi.AWREADY;
  assign w_hs    = s_axi.WVALID & s_axi.WREADY;
  assign commit  = aw_full_reg & w_full_reg & (~bvalid | s_axi.BREADY);
  assign addr_ok = 32'(aw_addr_reg) < 32'(MEM_DEPTH);

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      alive_reg   <= 1'b0;
      aw_full_reg <= 1'b0;
      aw_addr_reg <= '0;
      w_full_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      alive_reg <= 1'b1;
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_addr_reg <= s_axi.AWADDR;
      end else if (commit) begin
        aw_full_reg <= 1'b0;
      end
      if (w_hs) begin
        w_full_reg <= 1'b1;
        w_data_reg <= s_axi.WDATA;
        w_strb_reg <= s_axi.WSTRB;
      end else if (commit) begin
        w_full_reg <= 1'b0;
      end
      if (commit) begin
        bresp_reg <= addr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      b_state_reg <= B_IDLE;
    end else begin
      b_state_reg <= b_state_next;
    end
  end

  // A commit in the same cycle the master takes a response keeps BVALID high.
  always_comb begin
    b_state_next = b_state_reg;
    case (b_state_reg)
      B_IDLE: if (commit) b_state_next = B_WAIT;
      B_WAIT: if (s_axi.BREADY && !commit) b_state_next = B_IDLE;
    endcase
  end

  axi_lite_pixel_sink_pixel_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_pixel_ram (
    .ACLK    (ACLK),
    .reset   (reset),
    .wr_en   (commit & addr_ok),
    .wr_addr (aw_addr_reg),
    .wr_data (w_data_reg),
    .wr_strb (w_strb_reg),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef FRAME_IRQ_EN
  logic [15:0] frame_cnt_reg;
  logic        frame_irq_reg;
  logic        frame_hit;

  // 17-bit compare so FRAME_WORDS = 65536 is reachable from a 16-bit count.
  assign frame_hit = (({1'b0, frame_cnt_reg} + 17'd1) == 17'(FRAME_WORDS));

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      frame_cnt_reg <= '0;
      frame_irq_reg <= 1'b0;
    end else begin
      frame_irq_reg <= 1'b0;
      if (commit && addr_ok) begin
        if (frame_hit) begin
          frame_cnt_reg <= '0;
          frame_irq_reg <= 1'b1;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign frame_done_irq = frame_irq_reg;
`else
  localparam int unused_frame_words = FRAME_WORDS;
`endif

endmodule
